// File: rtl/bpred_btb_if.sv
// Fetch/resolve bus of the branch predictor / branch target buffer.
// The master side is the pipeline (fetch lookup + execute writeback),
// the slave side is the predictor itself.
interface bpred_btb_if #(
  parameter int XLEN      = 32,
  parameter int STAT_BITS = 32
);

  // Status
  logic                 ready;

  // Fetch-side lookup
  logic [XLEN-1:0]      lk_pc;
  logic                 lk_valid;
  logic                 pred_taken;
  logic [XLEN-1:0]      pred_target;

  // Resolve-side training
  logic                 upd_valid;
  logic [XLEN-1:0]      upd_pc;
  logic                 upd_taken;
  logic [XLEN-1:0]      upd_target;
  logic                 upd_pred_taken;
  logic                 mispredict;

  // Statistics
  logic [STAT_BITS-1:0] stat_branches;
  logic [STAT_BITS-1:0] stat_mispredicts;

  modport master (
    input  ready,
    output lk_pc, lk_valid,
    input  pred_taken, pred_target,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  mispredict,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    output ready,
    input  lk_pc, lk_valid,
    output pred_taken, pred_target,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output mispredict,
    output stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/bpred_btb.sv
// Dynamic branch predictor with branch target buffer.
// Direct-mapped table of {valid, tag, target, saturating counter}, indexed
// by pc[IDX_BITS+1:2]. Lookup is purely combinational; training happens at
// the clock edge from the resolve stage. After reset the table is swept
// clean one entry per cycle before the predictor reports ready.
// The interface XLEN/STAT_BITS parameters must match the module's.
module bpred_btb #(
  parameter int XLEN      = 32,
  parameter int IDX_BITS  = 6,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 32
) (
  input  logic       clk,
  input  logic       reset,
  bpred_btb_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Counter encodings: all-ones saturation, weakly-not-taken and weakly-taken
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_WNT + CTR_BITS'(1);

  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t               state;
  logic                 ready_q;
  logic [IDX_BITS-1:0]  init_idx;
  logic [STAT_BITS-1:0] stat_br_q;
  logic [STAT_BITS-1:0] stat_mp_q;

  // Entry storage
  logic                 valid_mem [ENTRIES];
  logic [TAG_BITS-1:0]  tag_mem   [ENTRIES];
  logic [XLEN-1:0]      tgt_mem   [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_mem   [ENTRIES];

  // Lookup side
  logic [IDX_BITS-1:0]  lk_idx;
  logic [TAG_BITS-1:0]  lk_tag;
  logic                 lk_hit;
  logic                 lk_taken;

  // Update side
  logic [IDX_BITS-1:0]  upd_idx;
  logic [TAG_BITS-1:0]  upd_tag;
  logic                 upd_hit;
  logic                 upd_fire;
  logic                 upd_misp;
  logic [CTR_BITS-1:0]  ctr_cur;
  logic [CTR_BITS-1:0]  ctr_up;
  logic [CTR_BITS-1:0]  ctr_dn;

  // Only the index/tag slices of the PCs steer the table; this absorbs the rest
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lk_pc, bus.upd_pc};

  // Combinational lookup against the current (pre-update) table contents
  always_comb begin
    lk_idx   = bus.lk_pc[IDX_BITS+1:2];
    lk_tag   = bus.lk_pc[IDX_BITS+2 +: TAG_BITS];
    lk_hit   = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    lk_taken = ready_q && bus.lk_valid && lk_hit && ctr_mem[lk_idx][CTR_BITS-1];
  end

  // Decode the resolved branch and precompute the saturated counter steps
  always_comb begin
    upd_idx  = bus.upd_pc[IDX_BITS+1:2];
    upd_tag  = bus.upd_pc[IDX_BITS+2 +: TAG_BITS];
    upd_hit  = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    upd_fire = ready_q && bus.upd_valid;
    upd_misp = upd_fire && (bus.upd_taken ^ bus.upd_pred_taken);
    ctr_cur  = ctr_mem[upd_idx];
    ctr_up   = (ctr_cur == CTR_MAX) ? CTR_MAX : ctr_cur + CTR_BITS'(1);
    ctr_dn   = (ctr_cur == '0) ? '0 : ctr_cur - CTR_BITS'(1);
  end

  // Init/run sequencer, ready flag and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      ready_q   <= 1'b0;
      init_idx  <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + IDX_BITS'(1);
          if (init_idx == '1) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.upd_valid) begin
            if (stat_br_q != STAT_MAX) stat_br_q <= stat_br_q + STAT_BITS'(1);
            if (upd_misp && (stat_mp_q != STAT_MAX)) stat_mp_q <= stat_mp_q + STAT_BITS'(1);
          end
        end
        default: begin
          state   <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Table writes: clearing sweep while initialising, training once running
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        valid_mem[init_idx] <= 1'b0;
        ctr_mem[init_idx]   <= CTR_WNT;
      end else if (upd_fire) begin
        if (upd_hit) begin
          if (bus.upd_taken) begin
            ctr_mem[upd_idx] <= ctr_up;
            tgt_mem[upd_idx] <= bus.upd_target;
          end else begin
            ctr_mem[upd_idx] <= ctr_dn;
          end
        end else if (bus.upd_taken) begin
          valid_mem[upd_idx] <= 1'b1;
          tag_mem[upd_idx]   <= upd_tag;
          tgt_mem[upd_idx]   <= bus.upd_target;
          ctr_mem[upd_idx]   <= CTR_WT;
        end
      end
    end
  end

  assign bus.ready            = ready_q;
  assign bus.pred_taken       = lk_taken;
  assign bus.pred_target      = lk_taken ? tgt_mem[lk_idx] : bus.lk_pc + XLEN'(4);
  assign bus.mispredict       = upd_misp;
  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_bpred_btb.sv
// Testbench for bpred_btb with 16 entries, 8-bit tags, 2-bit counters and
// 4-bit statistics. Expected values come from a table model that applies
// the predictor rules with plain integer arithmetic.
module tb_bpred_btb;

  localparam int N        = 16;
  localparam int CTR_TOP  = 3;
  localparam int STAT_TOP = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bpred_btb_if #(.XLEN(32), .STAT_BITS(4)) bus ();

  bpred_btb #(
    .XLEN(32), .IDX_BITS(4), .TAG_BITS(8), .CTR_BITS(2), .STAT_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_valid [N];
  int          m_tag   [N];
  int          m_ctr   [N];
  logic [31:0] m_target[N];
  int          m_init_left;
  int          m_br;
  int          m_mp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  // Model prediction for a lookup against the current model table
  task automatic model_predict(input logic [31:0] pc, input bit v,
                               output bit t, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    t  = (m_init_left == 0) && v && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = t ? m_target[i] : pc + 32'd4;
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT
  task automatic tick();
    if (reset) begin
      m_init_left = N;
      m_br = 0;
      m_mp = 0;
      foreach (m_valid[k]) m_valid[k] = 1'b0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (bus.upd_valid) begin
      int i;
      i = idx_of(bus.upd_pc);
      if (m_br < STAT_TOP) m_br++;
      if ((bus.upd_taken != bus.upd_pred_taken) && (m_mp < STAT_TOP)) m_mp++;
      if (m_valid[i] && (m_tag[i] == tag_of(bus.upd_pc))) begin
        if (bus.upd_taken) begin
          if (m_ctr[i] < CTR_TOP) m_ctr[i]++;
          m_target[i] = bus.upd_target;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (bus.upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(bus.upd_pc);
        m_target[i] = bus.upd_target;
        m_ctr[i]    = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lk_valid       = 1'b0;
    bus.lk_pc          = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;
    bus.upd_pred_taken = 1'b0;
  endtask

  task automatic drive_update(input logic [31:0] pc, input bit taken,
                              input logic [31:0] target, input bit pred);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = taken;
    bus.upd_target     = target;
    bus.upd_pred_taken = pred;
  endtask

  task automatic drive_lookup(input logic [31:0] pc);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
  endtask

  task automatic test_reset();
    bit          et;
    logic [31:0] eg;
    idle_inputs();
    reset = 1'b1;
    drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < N; c++) begin
      drive_lookup($urandom);
      drive_update($urandom, 1'b1, $urandom, 1'b0);
      #1;
      model_predict(bus.lk_pc, 1'b1, et, eg);
      checks++;
      if (bus.ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL init_ready cycle %0d: got %b expected 0", c, bus.ready);
      end
      checks++;
      if (bus.pred_taken !== et || bus.pred_target !== eg) begin
        failures++;
        $display("[TB] FAIL init_lookup cycle %0d: got %b/%h expected %b/%h", c, bus.pred_taken, bus.pred_target, et, eg);
      end
      checks++;
      if (bus.mispredict !== 1'b0 || bus.stat_branches !== 4'(m_br) || bus.stat_mispredicts !== 4'(m_mp)) begin
        failures++;
        $display("[TB] FAIL init_stats cycle %0d: got misp=%b br=%0d mp=%0d expected 0/%0d/%0d", c, bus.mispredict, bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.ready !== (m_init_left == 0)) begin
      failures++;
      $display("[TB] FAIL ready_after_init: got %b expected %b", bus.ready, m_init_left == 0);
    end
    checks++;
    if (bus.stat_branches !== 4'(m_br) || bus.stat_mispredicts !== 4'(m_mp)) begin
      failures++;
      $display("[TB] FAIL stats_after_init: got %0d/%0d expected %0d/%0d", bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
    end
  endtask

  task automatic test_allocate();
    bit          et;
    logic [31:0] eg;
    drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    #1;
    checks++;
    if (bus.mispredict !== 1'b1) begin
      failures++;
      $display("[TB] FAIL alloc_mispredict: got %b expected 1", bus.mispredict);
    end
    tick();
    idle_inputs();
    drive_lookup(32'h100);
    #1;
    model_predict(32'h100, 1'b1, et, eg);
    checks++;
    if (bus.pred_taken !== et || bus.pred_target !== eg) begin
      failures++;
      $display("[TB] FAIL alloc_lookup: got %b/%h expected %b/%h", bus.pred_taken, bus.pred_target, et, eg);
    end
    checks++;
    if (bus.stat_mispredicts !== 4'(m_mp) || bus.stat_branches !== 4'(m_br)) begin
      failures++;
      $display("[TB] FAIL alloc_stats: got %0d/%0d expected %0d/%0d", bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
    end
  endtask

  task automatic test_counter();
    bit          seq [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          et;
    logic [31:0] eg;
    for (int s = 0; s < 8; s++) begin
      idle_inputs();
      drive_update(32'h100, seq[s], 32'h80 + 32'(s * 8), 1'b1);
      tick();
      idle_inputs();
      drive_lookup(32'h100);
      #1;
      model_predict(32'h100, 1'b1, et, eg);
      checks++;
      if (bus.pred_taken !== et || bus.pred_target !== eg) begin
        failures++;
        $display("[TB] FAIL counter_step %0d: got %b/%h expected %b/%h", s, bus.pred_taken, bus.pred_target, et, eg);
      end
    end
  endtask

  task automatic test_alias();
    bit          et;
    logic [31:0] eg;
    logic [31:0] pcs [3] = '{32'h500, 32'h500, 32'h100};
    drive_update(32'h100, 1'b1, 32'h80, 1'b1);
    tick();
    idle_inputs();
    drive_lookup(32'h500);
    #1;
    model_predict(32'h500, 1'b1, et, eg);
    checks++;
    if (bus.pred_taken !== et || bus.pred_target !== eg) begin
      failures++;
      $display("[TB] FAIL alias_before: got %b/%h expected %b/%h", bus.pred_taken, bus.pred_target, et, eg);
    end
    drive_update(32'h500, 1'b1, 32'h40, 1'b0);
    tick();
    idle_inputs();
    for (int k = 1; k < 3; k++) begin
      drive_lookup(pcs[k]);
      #1;
      model_predict(pcs[k], 1'b1, et, eg);
      checks++;
      if (bus.pred_taken !== et || bus.pred_target !== eg) begin
        failures++;
        $display("[TB] FAIL alias_after pc=%h: got %b/%h expected %b/%h", pcs[k], bus.pred_taken, bus.pred_target, et, eg);
      end
    end
  endtask

  task automatic test_same_cycle();
    bit          et;
    logic [31:0] eg;
    idle_inputs();
    drive_lookup(32'h200);
    drive_update(32'h200, 1'b1, 32'h300, 1'b0);
    #1;
    model_predict(32'h200, 1'b1, et, eg);
    checks++;
    if (bus.pred_taken !== et || bus.pred_target !== eg) begin
      failures++;
      $display("[TB] FAIL same_cycle_pre: got %b/%h expected %b/%h", bus.pred_taken, bus.pred_target, et, eg);
    end
    tick();
    bus.upd_valid = 1'b0;
    #1;
    model_predict(32'h200, 1'b1, et, eg);
    checks++;
    if (bus.pred_taken !== et || bus.pred_target !== eg) begin
      failures++;
      $display("[TB] FAIL same_cycle_post: got %b/%h expected %b/%h", bus.pred_taken, bus.pred_target, et, eg);
    end
  endtask

  task automatic test_random();
    bit          et;
    bit          em;
    logic [31:0] eg;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(99) == 0);
      bus.lk_valid       = $urandom_range(3) != 0;
      bus.lk_pc          = 32'(($urandom_range(3) << 6) | ($urandom_range(15) << 2) | ($urandom_range(1) << 20));
      bus.upd_valid      = $urandom_range(1);
      bus.upd_pc         = 32'(($urandom_range(3) << 6) | ($urandom_range(15) << 2) | ($urandom_range(1) << 24));
      bus.upd_taken      = $urandom_range(1);
      bus.upd_target     = $urandom;
      bus.upd_pred_taken = $urandom_range(1);
      if ($urandom_range(7) == 0) bus.lk_pc = 32'hFFFF_FFFC;
      #1;
      model_predict(bus.lk_pc, bus.lk_valid, et, eg);
      em = (m_init_left == 0) && bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken);
      checks++;
      if (bus.ready !== (m_init_left == 0)) begin
        failures++;
        $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", c, bus.ready, m_init_left == 0);
      end
      checks++;
      if (bus.pred_taken !== et || bus.pred_target !== eg) begin
        failures++;
        $display("[TB] FAIL rand_lookup cycle %0d pc=%h: got %b/%h expected %b/%h", c, bus.lk_pc, bus.pred_taken, bus.pred_target, et, eg);
      end
      checks++;
      if (bus.mispredict !== em) begin
        failures++;
        $display("[TB] FAIL rand_mispredict cycle %0d: got %b expected %b", c, bus.mispredict, em);
      end
      checks++;
      if (bus.stat_branches !== 4'(m_br) || bus.stat_mispredicts !== 4'(m_mp)) begin
        failures++;
        $display("[TB] FAIL rand_stats cycle %0d: got %0d/%0d expected %0d/%0d", c, bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_mid_reset_saturate();
    bit          et;
    logic [31:0] eg;
    while (m_init_left > 0) tick();
    drive_update(32'h240, 1'b1, 32'h1234, 1'b0);
    tick();
    tick();
    idle_inputs();
    drive_lookup(32'h240);
    #1;
    model_predict(32'h240, 1'b1, et, eg);
    checks++;
    if (bus.pred_taken !== et || bus.pred_target !== eg) begin
      failures++;
      $display("[TB] FAIL trained_before_reset: got %b/%h expected %b/%h", bus.pred_taken, bus.pred_target, et, eg);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < N; c++) tick();
    drive_lookup(32'h240);
    #1;
    model_predict(32'h240, 1'b1, et, eg);
    checks++;
    if (bus.ready !== 1'b1 || bus.pred_taken !== et || bus.pred_target !== eg) begin
      failures++;
      $display("[TB] FAIL post_reset_lookup: got rdy=%b %b/%h expected 1 %b/%h", bus.ready, bus.pred_taken, bus.pred_target, et, eg);
    end
    checks++;
    if (bus.stat_branches !== 4'd0 || bus.stat_mispredicts !== 4'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_stats: got %0d/%0d expected 0/0", bus.stat_branches, bus.stat_mispredicts);
    end
    for (int c = 0; c < 20; c++) begin
      et = $urandom_range(1);
      drive_update($urandom, et, $urandom, !et);
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.stat_branches !== 4'(m_br) || bus.stat_mispredicts !== 4'(m_mp) || m_br != STAT_TOP) begin
      failures++;
      $display("[TB] FAIL stats_saturate: got %0d/%0d expected %0d/%0d", bus.stat_branches, bus.stat_mispredicts, m_br, m_mp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    m_init_left = N;
    m_br        = 0;
    m_mp        = 0;
    foreach (m_valid[k]) begin
      m_valid[k]  = 1'b0;
      m_tag[k]    = 0;
      m_ctr[k]    = 1;
      m_target[k] = '0;
    end
    idle_inputs();
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_random();
    test_mid_reset_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised dynamic branch predictor and branch target buffer; successor to the static jump-control block.
- Fetch stage queries it with the current PC and gets a taken/not-taken prediction plus a target, combinationally.
- Execute/resolve stage writes back the actual outcome each branch, which trains saturating counters and allocates entries.
- Keeps branch and mispredict statistics counters.

Parameters:
- XLEN, 32, address/target width.
- IDX_BITS, 6, log2 of entry count (2^IDX_BITS entries), index = pc[IDX_BITS+1:2].
- TAG_BITS, 8, tag = pc[IDX_BITS+2 +: TAG_BITS]; IDX_BITS+TAG_BITS+2 <= XLEN.
- CTR_BITS, 2, saturating counter width (>=1).
- STAT_BITS, 32, statistics counter width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- ready, output, 1, high when init sweep is done and the predictor is usable.
- lk_pc, input, XLEN, fetch PC to look up.
- lk_valid, input, 1, lookup request.
- pred_taken, output, 1, predicted taken.
- pred_target, output, XLEN, predicted next PC.
- upd_valid, input, 1, resolved conditional branch this cycle.
- upd_pc, input, XLEN, PC of the resolved branch.
- upd_taken, input, 1, actual outcome.
- upd_target, input, XLEN, actual taken target (pc+imm).
- upd_pred_taken, input, 1, prediction that was used for this branch.
- mispredict, output, 1, combinational: upd_valid && ready && (upd_taken ^ upd_pred_taken).
- stat_branches, output, STAT_BITS, resolved branch count.
- stat_mispredicts, output, STAT_BITS, mispredict count.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Entry fields: valid, tag, target[XLEN-1:0], ctr[CTR_BITS-1:0]. Constant WNT = 2^(CTR_BITS-1)-1; WT = WNT+1.
- FSM states: INIT and RUN.
  - reset=1 at an edge: state<=INIT, init_idx<=0, both stats<=0. Applies mid-operation too: the sweep restarts from index 0.
  - INIT: each cycle writes entry[init_idx] to valid=0, ctr=WNT, then increments init_idx. When init_idx == 2^IDX_BITS-1 is written, go to RUN.
  - INIT lasts exactly 2^IDX_BITS cycles after reset deasserts. ready=0 throughout INIT; updates are ignored and stats are not counted.
  - RUN: ready=1. Stays in RUN until the next reset.
- Lookup (combinational from lk_pc and the array):
  - hit = valid && tag match at index(lk_pc).
  - pred_taken = ready && lk_valid && hit && ctr[CTR_BITS-1].
  - pred_target = pred_taken ? entry.target : lk_pc+4 (wraps modulo 2^XLEN).
- Update (registered at the edge when ready && upd_valid), on entry at index(upd_pc):
  - Hit, taken: ctr = min(ctr+1, all-ones); target <= upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate, overwriting any previous occupant: valid=1, tag, target=upd_target, ctr=WT.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents. The write is visible the next cycle. No bypass.
- Stats, when ready && upd_valid:
  - stat_branches increments.
  - stat_mispredicts increments if mispredict.
  - Both saturate at all-ones (no wrap).
- All reset values: ready=0, pred_taken=0, pred_target=lk_pc+4, stats=0, mispredict=0.

Test Plan (IDX_BITS=4, TAG_BITS=8, CTR_BITS=2):
1. Reset 1 cycle then release -> ready=0 for exactly 16 cycles, then 1. Lookup during INIT with any pc gives pred_taken=0, pred_target=pc+4. upd_valid during INIT leaves the stats at 0.
2. After init, update pc=0x100, taken, target=0x80, pred=0 -> mispredict=1, stat_mispredicts=1. Next-cycle lookup 0x100 gives pred_taken=1, pred_target=0x80.
3. Two not-taken updates at 0x100 -> ctr goes 2→1→0 and the lookup gives pred_taken=0. Then three taken updates -> ctr saturates at 3. A fourth taken update keeps ctr=3.
4. Aliasing: entry for pc=0x100 trained taken; lookup pc=0x500 (same index 0, different tag) -> pred_taken=0. A taken update at 0x500 with target 0x40 replaces the entry, and 0x100 now misses.
5. Same-cycle lookup and update at 0x200 (fresh, taken, target 0x300) -> that cycle pred_taken=0; the next cycle pred_taken=1, target=0x300.
6. Reset asserted mid-RUN with trained entries -> INIT restarts. After 16 cycles all lookups miss and the stats read 0. With STAT_BITS=4, 20 mispredicting updates leave both stats at 15.
